// File: rtl/l2_banked_mem_2p_if.sv
// Line-request channel between an AXI-to-memory converter and the L2 core.
// master drives requests, slave grants them and returns responses.
interface l2_banked_mem_2p_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 128
);
    logic                    req;
    logic                    gnt;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    we;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] be;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;

    modport master (
        output req, addr, we, wdata, be,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, wdata, be,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/l2_banked_mem_2p.sv
// Dual-port banked L2 line memory over a grid of single-port SRAM cuts.
// Column conflicts between ports are settled round-robin; responses at latency 2.
module l2_banked_mem_2p #(
    parameter int DATA_WIDTH  = 128,
    parameter int CUT_DW      = 64,
    parameter int CUT_N_WORDS = 256,
    parameter int N_BYTES     = 8192
) (
    input logic               clk,
    input logic               rst,
    l2_banked_mem_2p_if.slave a,
    l2_banked_mem_2p_if.slave b
);
    localparam int N_PAR      = DATA_WIDTH / CUT_DW;
    localparam int N_SER      = N_BYTES * 8 / (DATA_WIDTH * CUT_N_WORDS);
    localparam int ADDR_WIDTH = $clog2(CUT_N_WORDS * N_SER);
    localparam int WORD_W     = $clog2(CUT_N_WORDS);
    localparam int ROW_W      = (N_SER > 1) ? $clog2(N_SER) : 1;
    localparam int NB         = DATA_WIDTH / 8;
    localparam int CUT_NB     = CUT_DW / 8;

    logic [1:0]            req;
    logic [1:0]            we;
    logic [1:0]            gnt;
    logic [ADDR_WIDTH-1:0] addr  [2];
    logic [DATA_WIDTH-1:0] wdata [2];
    logic [NB-1:0]         be    [2];
    logic [WORD_W-1:0]     word  [2];
    logic [ROW_W-1:0]      row   [2];
    logic [N_PAR-1:0]      fp    [2];
    logic                  contend;
    logic                  rr_q;

    assign req      = {b.req, a.req};
    assign we       = {b.we, a.we};
    assign addr[0]  = a.addr;
    assign addr[1]  = b.addr;
    assign wdata[0] = a.wdata;
    assign wdata[1] = b.wdata;
    assign be[0]    = a.be;
    assign be[1]    = b.be;

    for (genvar p = 0; p < 2; p++) begin : g_port
        assign word[p] = addr[p][WORD_W-1:0];
        if (N_SER > 1) begin : g_row
            assign row[p] = addr[p][ADDR_WIDTH-1:WORD_W];
        end else begin : g_norow
            assign row[p] = '0;
        end
    end

    // Reads claim every column; writes only columns with enabled bytes.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            fp[p] = '0;
            for (int c = 0; c < N_PAR; c++) begin
                fp[p][c] = req[p] &
                           (~we[p] | (|be[p][c*CUT_NB +: CUT_NB]));
            end
        end
        contend = |(fp[0] & fp[1]);
        gnt = '0;
        if (!rst) begin
            gnt[0] = req[0] & (~contend | ~rr_q);
            gnt[1] = req[1] & (~contend | rr_q);
        end
    end

    logic [N_PAR-1:0]  col_req;
    logic [N_PAR-1:0]  col_we;
    logic [N_PAR-1:0]  col_b;
    logic [ROW_W-1:0]  col_row   [N_PAR];
    logic [WORD_W-1:0] col_word  [N_PAR];
    logic [CUT_DW-1:0] col_wdata [N_PAR];
    logic [CUT_NB-1:0] col_be    [N_PAR];

    // Granted footprints never overlap, so each column has at most one owner.
    always_comb begin
        for (int c = 0; c < N_PAR; c++) begin
            col_b[c]     = gnt[1] & fp[1][c];
            col_req[c]   = (gnt[0] & fp[0][c]) | col_b[c];
            col_we[c]    = col_b[c] ? we[1] : we[0];
            col_row[c]   = col_b[c] ? row[1] : row[0];
            col_word[c]  = col_b[c] ? word[1] : word[0];
            col_wdata[c] = col_b[c] ? wdata[1][c*CUT_DW +: CUT_DW]
                                    : wdata[0][c*CUT_DW +: CUT_DW];
            col_be[c]    = col_b[c] ? be[1][c*CUT_NB +: CUT_NB]
                                    : be[0][c*CUT_NB +: CUT_NB];
        end
    end

    logic [CUT_DW-1:0] cut_q [N_PAR][N_SER];

    for (genvar c = 0; c < N_PAR; c++) begin : g_col
        for (genvar r = 0; r < N_SER; r++) begin : g_cut
            logic [CUT_DW-1:0] mem [CUT_N_WORDS];
            logic [CUT_DW-1:0] q;
            logic              sel;

            assign sel = col_req[c] && (col_row[c] == ROW_W'(r));

            always_ff @(posedge clk) begin
                if (sel && col_we[c]) begin
                    for (int i = 0; i < CUT_NB; i++) begin
                        if (col_be[c][i]) begin
                            mem[col_word[c]][i*8 +: 8] <=
                                col_wdata[c][i*8 +: 8];
                        end
                    end
                end
                if (sel && !col_we[c]) begin
                    q <= mem[col_word[c]];
                end
            end

            assign cut_q[c][r] = q;
        end
    end

    logic [1:0]            v1_q;
    logic [1:0]            v2_q;
    logic [1:0]            rd1_q;
    logic [ROW_W-1:0]      row_q   [2];
    logic [DATA_WIDTH-1:0] rmux    [2];
    logic [DATA_WIDTH-1:0] rdata_q [2];

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rmux[p] = '0;
            for (int c = 0; c < N_PAR; c++) begin
                rmux[p][c*CUT_DW +: CUT_DW] = cut_q[c][row_q[p]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q  <= '0;
            v2_q  <= '0;
            rd1_q <= '0;
            rr_q  <= 1'b0;
            for (int p = 0; p < 2; p++) begin
                row_q[p]   <= '0;
                rdata_q[p] <= '0;
            end
        end else begin
            v1_q  <= gnt;
            v2_q  <= v1_q;
            rd1_q <= gnt & ~we;
            if (contend) begin
                rr_q <= ~rr_q;
            end
            for (int p = 0; p < 2; p++) begin
                if (gnt[p]) begin
                    row_q[p] <= row[p];
                end
                if (rd1_q[p]) begin
                    rdata_q[p] <= rmux[p];
                end
            end
        end
    end

    assign a.gnt    = gnt[0];
    assign b.gnt    = gnt[1];
    assign a.rvalid = v2_q[0] & ~rst;
    assign b.rvalid = v2_q[1] & ~rst;
    assign a.rdata  = rst ? '0 : rdata_q[0];
    assign b.rdata  = rst ? '0 : rdata_q[1];

    a_params: assert property (@(posedge clk)
        (DATA_WIDTH % CUT_DW == 0) &&
        ((DATA_WIDTH & (DATA_WIDTH - 1)) == 0) &&
        ((CUT_DW & (CUT_DW - 1)) == 0) && (CUT_DW >= 8) &&
        ((CUT_N_WORDS & (CUT_N_WORDS - 1)) == 0) &&
        (N_BYTES % (N_PAR * CUT_DW * CUT_N_WORDS / 8) == 0) &&
        ($bits(a.addr) == ADDR_WIDTH) && ($bits(b.addr) == ADDR_WIDTH));

    a_hold_a: assert property (@(posedge clk) disable iff (rst)
        a.req && !a.gnt |=> a.req && $stable(a.addr) && $stable(a.we) &&
        $stable(a.wdata) && $stable(a.be));

    a_hold_b: assert property (@(posedge clk) disable iff (rst)
        b.req && !b.gnt |=> b.req && $stable(b.addr) && $stable(b.we) &&
        $stable(b.wdata) && $stable(b.be));
endmodule

// File: tb/tb_l2_banked_mem_2p.sv
// Directed bench for l2_banked_mem_2p: access latency, row decode,
// byte enables, disjoint grants, round-robin conflicts, reset drop.
module tb_l2_banked_mem_2p;
    localparam int DW = 128;
    localparam int AW = 9;
    localparam int BW = DW / 8;

    localparam logic [DW-1:0] D1   = 128'h112233445566778899AABBCCDDEEFF00;
    localparam logic [DW-1:0] D3   = 128'hDEADBEEF00000003CAFEF00D30303030;
    localparam logic [DW-1:0] D259 = 128'h1234567800000103876543210A5A5A5A;
    localparam logic [DW-1:0] DAA  = {16{8'hAA}};
    localparam logic [DW-1:0] DN   = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [DW-1:0] DX   = 128'h1111111111111111_2222222222222222;
    localparam logic [DW-1:0] DY   = 128'h3333333333333333_4444444444444444;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    l2_banked_mem_2p_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) a_if ();
    l2_banked_mem_2p_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b_if ();

    l2_banked_mem_2p #(
        .DATA_WIDTH(DW), .CUT_DW(64), .CUT_N_WORDS(256), .N_BYTES(8192)
    ) dut (
        .clk(clk),
        .rst(rst),
        .a  (a_if),
        .b  (b_if)
    );

    task automatic drive(input bit p, input bit rq, input bit w,
                         input logic [AW-1:0] ad, input logic [DW-1:0] wd,
                         input logic [BW-1:0] be);
        if (p) begin
            b_if.req = rq; b_if.we = w; b_if.addr = ad;
            b_if.wdata = wd; b_if.be = be;
        end else begin
            a_if.req = rq; a_if.we = w; a_if.addr = ad;
            a_if.wdata = wd; a_if.be = be;
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // One isolated access: grant sampled in cycle t, response in t+2.
    task automatic access(input bit p, input bit w, input logic [AW-1:0] ad,
                          input logic [DW-1:0] wd, input logic [BW-1:0] be,
                          output bit g, output bit rv,
                          output logic [DW-1:0] rd);
        drive(p, 1'b1, w, ad, wd, be);
        #1;
        g = p ? b_if.gnt : a_if.gnt;
        step();
        drive(p, 1'b0, 1'b0, '0, '0, '0);
        step();
        #1;
        rv = p ? b_if.rvalid : a_if.rvalid;
        rd = p ? b_if.rdata : a_if.rdata;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 9'd5, '0, '0);
        drive(1'b1, 1'b1, 1'b0, 9'd3, '0, '0);
        step();
        step();
        total++;
        if (a_if.gnt !== 1'b0 || b_if.gnt !== 1'b0) begin
            bad++;
            $display("FAIL rst_gnt got=%b%b want=00", a_if.gnt, b_if.gnt);
        end
        total++;
        if (a_if.rvalid !== 1'b0 || b_if.rvalid !== 1'b0) begin
            bad++;
            $display("FAIL rst_rvalid got=%b%b want=00",
                     a_if.rvalid, b_if.rvalid);
        end
        total++;
        if (a_if.rdata !== '0 || b_if.rdata !== '0) begin
            bad++;
            $display("FAIL rst_rdata got=%h/%h want=0", a_if.rdata, b_if.rdata);
        end
        idle();
        rst = 1'b0;
        step();
    endtask

    task automatic test_write_read();
        bit g, rv;
        logic [DW-1:0] rd;
        access(1'b0, 1'b1, 9'd5, D1, '1, g, rv, rd);
        total++;
        if (g !== 1'b1 || rv !== 1'b1) begin
            bad++;
            $display("FAIL t1_wr gnt=%b rvalid=%b want=1/1", g, rv);
        end
        access(1'b0, 1'b0, 9'd5, '0, '0, g, rv, rd);
        total++;
        if (g !== 1'b1 || rv !== 1'b1) begin
            bad++;
            $display("FAIL t1_rd gnt=%b rvalid=%b want=1/1", g, rv);
        end
        total++;
        if (rd !== D1) begin
            bad++;
            $display("FAIL t1_rdata got=%h want=%h", rd, D1);
        end
    endtask

    task automatic test_row_decode();
        bit g, rv;
        logic [DW-1:0] rd;
        access(1'b0, 1'b1, 9'd3, D3, '1, g, rv, rd);
        access(1'b0, 1'b1, 9'd259, D259, '1, g, rv, rd);
        access(1'b0, 1'b0, 9'd3, '0, '0, g, rv, rd);
        total++;
        if (rv !== 1'b1 || rd !== D3) begin
            bad++;
            $display("FAIL t2_line3 rv=%b got=%h want=%h", rv, rd, D3);
        end
        access(1'b0, 1'b0, 9'd259, '0, '0, g, rv, rd);
        total++;
        if (rv !== 1'b1 || rd !== D259) begin
            bad++;
            $display("FAIL t2_line259 rv=%b got=%h want=%h", rv, rd, D259);
        end
    endtask

    task automatic test_partial();
        bit g, rv;
        logic [DW-1:0] rd;
        logic [DW-1:0] exp;
        exp = {DAA[127:64], DN[63:0]};
        access(1'b0, 1'b1, 9'd7, DAA, '1, g, rv, rd);
        access(1'b0, 1'b1, 9'd7, DN, 16'h00FF, g, rv, rd);
        total++;
        if (g !== 1'b1) begin
            bad++;
            $display("FAIL t3_wr_gnt got=%b want=1", g);
        end
        access(1'b1, 1'b0, 9'd7, '0, '0, g, rv, rd);
        total++;
        if (rv !== 1'b1 || rd !== exp) begin
            bad++;
            $display("FAIL t3_rdata rv=%b got=%h want=%h", rv, rd, exp);
        end
    endtask

    task automatic test_disjoint();
        logic [DW-1:0] exp;
        exp = {DY[127:64], DX[63:0]};
        drive(1'b0, 1'b1, 1'b1, 9'd10, DX, 16'h00FF);
        drive(1'b1, 1'b1, 1'b1, 9'd10, DY, 16'hFF00);
        #1;
        total++;
        if (a_if.gnt !== 1'b1 || b_if.gnt !== 1'b1) begin
            bad++;
            $display("FAIL t4_disjoint_gnt got=%b%b want=11",
                     a_if.gnt, b_if.gnt);
        end
        step();
        drive(1'b0, 1'b1, 1'b1, 9'd10, '1, 16'h0000);
        drive(1'b1, 1'b1, 1'b0, 9'd10, '0, '0);
        #1;
        total++;
        if (a_if.gnt !== 1'b1 || b_if.gnt !== 1'b1) begin
            bad++;
            $display("FAIL t4_be0_gnt got=%b%b want=11", a_if.gnt, b_if.gnt);
        end
        step();
        idle();
        step();
        #1;
        total++;
        if (a_if.rvalid !== 1'b1 || b_if.rvalid !== 1'b1) begin
            bad++;
            $display("FAIL t4_rvalid got=%b%b want=11",
                     a_if.rvalid, b_if.rvalid);
        end
        total++;
        if (b_if.rdata !== exp) begin
            bad++;
            $display("FAIL t4_rdata got=%h want=%h", b_if.rdata, exp);
        end
        step();
        step();
    endtask

    task automatic test_conflict();
        bit ega, egb, eva, evb;
        drive(1'b0, 1'b1, 1'b0, 9'd5, '0, '0);
        drive(1'b1, 1'b1, 1'b0, 9'd3, '0, '0);
        for (int c = 0; c < 8; c++) begin
            if (c == 4) drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
            if (c == 5) drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
            #1;
            ega = (c == 0 || c == 2 || c == 4);
            egb = (c == 1 || c == 3);
            eva = (c == 2 || c == 4 || c == 6);
            evb = (c == 3 || c == 5);
            total++;
            if (a_if.gnt !== ega || b_if.gnt !== egb) begin
                bad++;
                $display("FAIL t5_gnt c=%0d got=%b%b want=%b%b",
                         c, a_if.gnt, b_if.gnt, ega, egb);
            end
            total++;
            if (a_if.rvalid !== eva || b_if.rvalid !== evb) begin
                bad++;
                $display("FAIL t5_rvalid c=%0d got=%b%b want=%b%b",
                         c, a_if.rvalid, b_if.rvalid, eva, evb);
            end
            if (eva) begin
                total++;
                if (a_if.rdata !== D1) begin
                    bad++;
                    $display("FAIL t5_rdata_a c=%0d got=%h want=%h",
                             c, a_if.rdata, D1);
                end
            end
            if (evb) begin
                total++;
                if (b_if.rdata !== D3) begin
                    bad++;
                    $display("FAIL t5_rdata_b c=%0d got=%h want=%h",
                             c, b_if.rdata, D3);
                end
            end
            step();
        end
    endtask

    task automatic test_reset_inflight();
        drive(1'b0, 1'b1, 1'b0, 9'd5, '0, '0);
        drive(1'b1, 1'b1, 1'b0, 9'd3, '0, '0);
        #1;
        total++;
        if (a_if.gnt !== 1'b1 || b_if.gnt !== 1'b0) begin
            bad++;
            $display("FAIL t6_pre_gnt got=%b%b want=10", a_if.gnt, b_if.gnt);
        end
        step();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        #1;
        total++;
        if (a_if.gnt !== 1'b0 || b_if.gnt !== 1'b0) begin
            bad++;
            $display("FAIL t6_rst_gnt got=%b%b want=00", a_if.gnt, b_if.gnt);
        end
        step();
        rst = 1'b0;
        idle();
        for (int c = 0; c < 2; c++) begin
            #1;
            total++;
            if (a_if.rvalid !== 1'b0 || b_if.rvalid !== 1'b0) begin
                bad++;
                $display("FAIL t6_dropped c=%0d got=%b%b want=00",
                         c, a_if.rvalid, b_if.rvalid);
            end
            step();
        end
        drive(1'b0, 1'b1, 1'b0, 9'd5, '0, '0);
        drive(1'b1, 1'b1, 1'b0, 9'd3, '0, '0);
        #1;
        total++;
        if (a_if.gnt !== 1'b1 || b_if.gnt !== 1'b0) begin
            bad++;
            $display("FAIL t6_rr_after_rst got=%b%b want=10",
                     a_if.gnt, b_if.gnt);
        end
        step();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        #1;
        total++;
        if (b_if.gnt !== 1'b1) begin
            bad++;
            $display("FAIL t6_b_gnt got=%b want=1", b_if.gnt);
        end
        step();
        idle();
        #1;
        total++;
        if (a_if.rvalid !== 1'b1 || a_if.rdata !== D1) begin
            bad++;
            $display("FAIL t6_a_resp rv=%b got=%h want=%h",
                     a_if.rvalid, a_if.rdata, D1);
        end
        step();
        #1;
        total++;
        if (b_if.rvalid !== 1'b1 || b_if.rdata !== D3) begin
            bad++;
            $display("FAIL t6_b_resp rv=%b got=%h want=%h",
                     b_if.rvalid, b_if.rdata, D3);
        end
        step();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        step();
        test_reset();
        test_write_read();
        test_row_decode();
        test_partial();
        test_disjoint();
        test_conflict();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
